// File: rtl/pcie_axis_sf_pkt_fifo.sv
// ---------------------------------------------------------------------------
// pcie_axis_sf_pkt_fifo
// Single-clock store-and-forward packet FIFO for PCIe SS AXI-S streams.
// A packet is only presented on the source side once its tlast beat has been
// accepted on the sink side, so downstream never sees producer bubbles.
// A packet longer than the buffer triggers a sticky err_oversize and is
// forwarded cut-through so that the FIFO cannot deadlock.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   snk_t*                      AXI-S sink (tvalid/tready/tdata/tkeep/
//                               tuser_vendor/tlast)
//   src_t*                      AXI-S source, registered output stage
//   err_oversize                sticky: a packet exceeded DEPTH beats
//   pkt_fwd_cnt                 packets forwarded (saturating)
//
// Optional feature macro: PCIE_AXIS_SF_STATS_EN
//   defined   -> pkt_fwd_cnt counts source handshakes carrying tlast
//   undefined -> pkt_fwd_cnt is tied to zero
// ---------------------------------------------------------------------------
module pcie_axis_sf_pkt_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_W     = 512,
  parameter int USER_W     = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                snk_tvalid,
  output logic                snk_tready,
  input  logic [DATA_W-1:0]   snk_tdata,
  input  logic [DATA_W/8-1:0] snk_tkeep,
  input  logic [USER_W-1:0]   snk_tuser_vendor,
  input  logic                snk_tlast,
  output logic                src_tvalid,
  input  logic                src_tready,
  output logic [DATA_W-1:0]   src_tdata,
  output logic [DATA_W/8-1:0] src_tkeep,
  output logic [USER_W-1:0]   src_tuser_vendor,
  output logic                src_tlast,
  output logic                err_oversize,
  output logic [31:0]         pkt_fwd_cnt
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int PW     = DEPTH_LOG2 + 1;
  localparam int KEEP_W = DATA_W / 8;
  localparam int ENT_W  = DATA_W + KEEP_W + USER_W + 1;

  // Entry layout: {tdata, tkeep, tuser_vendor, tlast}; tlast is bit 0.
  logic [ENT_W-1:0] mem [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    pkt_avail_q, pkt_avail_d;
  logic             force_q, force_d;
  logic             err_q, err_d;
  logic             snk_tready_q, snk_tready_d;
  logic             src_tvalid_q, src_tvalid_d;
  logic [ENT_W-1:0] out_q, out_d;

  logic [PW-1:0]    used, used_d;
  logic             full, empty, wr_en, rd_en, rd_last, oversize;
  logic [ENT_W-1:0] rd_ent;

  assign used     = wptr_q - rptr_q;
  assign full     = (used == PW'(DEPTH));
  assign empty    = (used == '0);
  assign wr_en    = snk_tvalid & snk_tready_q;
  assign rd_ent   = mem[rptr_q[DEPTH_LOG2-1:0]];
  assign rd_last  = rd_ent[0];
  assign rd_en    = ~empty & ((pkt_avail_q != '0) | force_q) &
                    (~src_tvalid_q | src_tready);
  // Buffer full with no complete packet inside: the packet cannot fit.
  assign oversize = full & (pkt_avail_q == '0);

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    pkt_avail_d  = pkt_avail_q;
    force_d      = force_q;
    err_d        = err_q | oversize;
    src_tvalid_d = src_tvalid_q;
    out_d        = out_q;

    if (wr_en) wptr_d = wptr_q + PW'(1);
    if (rd_en) rptr_d = rptr_q + PW'(1);

    case ({wr_en & snk_tlast, rd_en & rd_last})
      2'b10:   pkt_avail_d = pkt_avail_q + PW'(1);
      2'b01:   pkt_avail_d = pkt_avail_q - PW'(1);
      default: pkt_avail_d = pkt_avail_q;
    endcase

    // A tlast beat leaving storage ends cut-through mode; a tlast beat
    // cannot be in storage while oversize holds, so the two never collide.
    if (rd_en && rd_last) force_d = 1'b0;
    else if (oversize)    force_d = 1'b1;

    if (rd_en) begin
      out_d        = rd_ent;
      src_tvalid_d = 1'b1;
    end else if (src_tready) begin
      src_tvalid_d = 1'b0;
    end

    used_d       = wptr_d - rptr_d;
    snk_tready_d = (used_d != PW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      pkt_avail_q  <= '0;
      force_q      <= 1'b0;
      err_q        <= 1'b0;
      snk_tready_q <= 1'b0;
      src_tvalid_q <= 1'b0;
      out_q        <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      pkt_avail_q  <= pkt_avail_d;
      force_q      <= force_d;
      err_q        <= err_d;
      snk_tready_q <= snk_tready_d;
      src_tvalid_q <= src_tvalid_d;
      out_q        <= out_d;
    end
  end

  // Storage array carries no reset; contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[DEPTH_LOG2-1:0]] <= {snk_tdata, snk_tkeep, snk_tuser_vendor, snk_tlast};
  end

  assign snk_tready       = snk_tready_q;
  assign src_tvalid       = src_tvalid_q;
  assign src_tdata        = out_q[ENT_W-1 -: DATA_W];
  assign src_tkeep        = out_q[USER_W+1 +: KEEP_W];
  assign src_tuser_vendor = out_q[1 +: USER_W];
  assign src_tlast        = out_q[0];
  assign err_oversize     = err_q;

`ifdef PCIE_AXIS_SF_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    if (src_tvalid_q && src_tready && out_q[0] && (fwd_cnt_q != 32'hFFFF_FFFF))
      fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fwd_cnt_q <= '0;
    else        fwd_cnt_q <= fwd_cnt_d;
  end

  assign pkt_fwd_cnt = fwd_cnt_q;
`else
  assign pkt_fwd_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pcie_axis_sf_pkt_fifo.sv
// ---------------------------------------------------------------------------
// tb_pcie_axis_sf_pkt_fifo
// Scoreboard bench: every accepted sink beat is queued, and a separate
// monitor pops and compares on every source handshake. The reference model
// is the packet-order rule itself: the source beat stream equals the sink
// beat stream, with timing points taken from the documented latencies.
// ---------------------------------------------------------------------------
module tb_pcie_axis_sf_pkt_fifo;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 10;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          snk_tvalid = 1'b0;
  logic          snk_tready;
  logic [DW-1:0] snk_tdata = '0;
  logic [KW-1:0] snk_tkeep = '0;
  logic [UW-1:0] snk_tuser_vendor = '0;
  logic          snk_tlast = 1'b0;
  logic          src_tvalid;
  logic          src_tready = 1'b0;
  logic [DW-1:0] src_tdata;
  logic [KW-1:0] src_tkeep;
  logic [UW-1:0] src_tuser_vendor;
  logic          src_tlast;
  logic          err_oversize;
  logic [31:0]   pkt_fwd_cnt;

  pcie_axis_sf_pkt_fifo #(.DEPTH_LOG2(6), .DATA_W(DW), .USER_W(UW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .snk_tvalid       (snk_tvalid),
    .snk_tready       (snk_tready),
    .snk_tdata        (snk_tdata),
    .snk_tkeep        (snk_tkeep),
    .snk_tuser_vendor (snk_tuser_vendor),
    .snk_tlast        (snk_tlast),
    .src_tvalid       (src_tvalid),
    .src_tready       (src_tready),
    .src_tdata        (src_tdata),
    .src_tkeep        (src_tkeep),
    .src_tuser_vendor (src_tuser_vendor),
    .src_tlast        (src_tlast),
    .err_oversize     (err_oversize),
    .pkt_fwd_cnt      (pkt_fwd_cnt)
  );

  initial forever #5 clk = ~clk;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    pushed = 0;
  int    popped = 0;
  int    exp_pkts = 0;
  bit    no_valid_chk = 1'b0;
  bit    rnd_bp = 1'b0;

  task automatic check1(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom;
    b.k = {$urandom, $urandom};
    b.u = UW'($urandom);
    b.l = last;
    return b;
  endfunction

  // Monitor: scoreboard push on sink handshakes, pop/compare on source ones.
  initial begin
    beat_t held, cur, exp;
    bit    prev_stall;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      cur = '{d: src_tdata, k: src_tkeep, u: src_tuser_vendor, l: src_tlast};
      if (prev_stall) begin
        checks++;
        if (!src_tvalid || cur !== held) begin
          errors++;
          $display("FAIL stable_under_stall: got v=%0b %h required v=1 %h", src_tvalid, cur, held);
        end
      end
      if (snk_tvalid && snk_tready) begin
        sb.push_back('{d: snk_tdata, k: snk_tkeep, u: snk_tuser_vendor, l: snk_tlast});
        pushed++;
      end
      if (no_valid_chk) check1("held_until_tlast", 64'(src_tvalid), 64'd0);
      if (src_tvalid && src_tready) begin
        checks++;
        popped++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h required no beat", cur);
        end else begin
          exp = sb.pop_front();
          if (cur !== exp) begin
            errors++;
            $display("FAIL beat_order: got %h required %h", cur, exp);
          end
        end
      end
      prev_stall = src_tvalid && !src_tready;
      held = cur;
    end
  end

  // Random source backpressure when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_bp) src_tready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // Drives one beat and returns at posedge+1 of the cycle after acceptance.
  task automatic send_beat(input beat_t b);
    int t = 0;
    snk_tvalid = 1'b1;
    snk_tdata = b.d;
    snk_tkeep = b.k;
    snk_tuser_vendor = b.u;
    snk_tlast = b.l;
    forever begin
      @(negedge clk);
      if (snk_tready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
      if (t > 2000) begin
        check1("sink_accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    snk_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      send_beat(rand_beat(i == len - 1));
      if (i != len - 1) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    exp_pkts++;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || src_tvalid) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check1("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Asserts reset at posedge+1, checks reset state, releases on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check1("rst_src_tvalid", 64'(src_tvalid), 64'd0);
    check1("rst_snk_tready", 64'(snk_tready), 64'd0);
    repeat (2) @(negedge clk);
    check1("rst_err", 64'(err_oversize), 64'd0);
    check1("rst_cnt", 64'(pkt_fwd_cnt), 64'd0);
    check1("rst_src_tlast", 64'(src_tlast), 64'd0);
    rst_n = 1'b1;
    exp_pkts = 0;
    #1;
    check1("rel_tready_still_0", 64'(snk_tready), 64'd0);
    @(negedge clk);
    check1("rel_tready_1", 64'(snk_tready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    beat_t b;
    int    base;
    int    t;

    @(posedge clk);
    #1;
    do_reset();

    // Single 1-beat packet: valid two cycles after acceptance.
    src_tready = 1'b1;
    b.d = {64{8'hA5}};
    b.k = '1;
    b.u = 10'h2A5;
    b.l = 1'b1;
    send_beat(b);
    exp_pkts++;
    @(negedge clk);
    check1("lat_n1_invalid", 64'(src_tvalid), 64'd0);
    @(negedge clk);
    check1("lat_n2_valid", 64'(src_tvalid), 64'd1);
    check1("lat_n2_tlast", 64'(src_tlast), 64'd1);
    wait_drain();

    // 4-beat packet with 3-cycle sink gaps: held, then streamed gap-free.
    no_valid_chk = 1'b1;
    send_pkt(4, 3);
    no_valid_chk = 1'b0;
    @(negedge clk);
    check1("gap_n1_invalid", 64'(src_tvalid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("gap_stream_valid", 64'(src_tvalid), 64'd1);
    end
    @(negedge clk);
    check1("gap_after_invalid", 64'(src_tvalid), 64'd0);
    wait_drain();

    // Fill with the source stalled. One beat sits in the output register,
    // so 64 storage beats plus that one are needed before sink stalls.
    @(posedge clk);
    #1;
    src_tready = 1'b0;
    for (int p = 0; p < 16; p++) send_pkt(4, 0);
    @(negedge clk);
    check1("fill64_tready_still_1", 64'(snk_tready), 64'd1);
    @(posedge clk);
    #1;
    send_pkt(1, 0);
    @(negedge clk);
    check1("full_tready_0", 64'(snk_tready), 64'd0);
    check1("full_out_valid", 64'(src_tvalid), 64'd1);
    @(posedge clk);
    #1;
    src_tready = 1'b1;
    @(negedge clk);
    check1("first_read_tready_0", 64'(snk_tready), 64'd0);
    @(negedge clk);
    check1("after_read_tready_1", 64'(snk_tready), 64'd1);
    wait_drain();

    // 70-beat oversize packet.
    check1("err_before_oversize", 64'(err_oversize), 64'd0);
    @(posedge clk);
    #1;
    base = pushed;
    fork
      send_pkt(70, 0);
      begin
        t = 0;
        while (!err_oversize && t < 500) begin
          @(posedge clk);
          #1;
          t++;
        end
        check1("oversize_flag", 64'(err_oversize), 64'd1);
        check1("oversize_at_64", 64'(pushed - base), 64'd64);
      end
    join
    wait_drain();
    check1("oversize_beats", 64'(pushed - base), 64'd70);
    check1("err_sticky", 64'(err_oversize), 64'd1);
    no_valid_chk = 1'b1;
    send_pkt(2, 2);
    no_valid_chk = 1'b0;
    @(negedge clk);
    check1("post_ovs_n1_invalid", 64'(src_tvalid), 64'd0);
    @(negedge clk);
    check1("post_ovs_valid0", 64'(src_tvalid), 64'd1);
    @(negedge clk);
    check1("post_ovs_valid1", 64'(src_tvalid), 64'd1);
    @(negedge clk);
    check1("post_ovs_done", 64'(src_tvalid), 64'd0);
    wait_drain();

    // Random backpressure over 200 random-length packets.
    @(posedge clk);
    #1;
    do_reset();
    rnd_bp = 1'b1;
    for (int p = 0; p < 200; p++) send_pkt($urandom_range(1, 16), $urandom_range(0, 2));
    @(posedge clk);
    #1;
    rnd_bp = 1'b0;
    src_tready = 1'b1;
    wait_drain();
`ifdef PCIE_AXIS_SF_STATS_EN
    check1("pkt_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_pkts));
`else
    check1("pkt_fwd_cnt_tied", 64'(pkt_fwd_cnt), 64'd0);
`endif

    // Reset during output of a packet, then a clean packet afterwards.
    src_tready = 1'b0;
    send_pkt(8, 0);
    @(posedge clk);
    #1;
    src_tready = 1'b1;
    base = popped;
    t = 0;
    while (popped < base + 3 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check1("mid_pkt_popped", 64'(popped - base), 64'd3);
    do_reset();
    base = popped;
    send_pkt(3, 0);
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    check1("post_reset_beats", 64'(popped - base), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
